// File: rtl/aes_core_arbiter_pkg.sv
// rtl/aes_core_arbiter_pkg.sv - shared encodings for the AES core arbiter
// State and keylen codes match the encipher core; owner codes double as key_sel values.
package aes_core_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    KEYLEN_AES128 = 1'b0,
    KEYLEN_AES256 = 1'b1
  } keylen_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

// File: rtl/aes_rr_arbiter2.sv
// rtl/aes_rr_arbiter2.sv - combinational two-way round-robin grant
// On a tie the requester that did not win last time is granted; last_grant is held by the parent.
module aes_rr_arbiter2
  import aes_core_arbiter_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  assign grant_valid = a_valid | b_valid;
  assign grant       = (a_valid && b_valid) ? (last_grant == OWNER_A) : b_valid;

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - shares one AES encipher core between requesters A and B
// One job in flight; a watchdog turns a silent core into an error response.
module aes_core_arbiter
  import aes_core_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20,
  parameter int CNT_W          = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic [127:0] a_req_block,
  input  logic         a_req_keylen,
  output logic         a_resp_valid,
  input  logic         a_resp_ready,
  output logic [127:0] a_resp_block,
  output logic         a_resp_err,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic [127:0] b_req_block,
  input  logic         b_req_keylen,
  output logic         b_resp_valid,
  input  logic         b_resp_ready,
  output logic [127:0] b_resp_block,
  output logic         b_resp_err,
  output logic         core_next,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic [127:0] core_new_block,
  input  logic         core_ready,
  output logic         key_sel
);

  arb_state_t       state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     result;
  logic             err;
  logic             grant_valid;
  logic             grant;
  logic             owner_resp_ready;

  aes_rr_arbiter2 u_arb (
    .a_valid     (a_req_valid),
    .b_valid     (b_req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign a_req_ready = (state == ST_IDLE) && grant_valid && (grant == OWNER_A);
  assign b_req_ready = (state == ST_IDLE) && grant_valid && (grant == OWNER_B);

  // key_sel also records the owner of the job in flight.
  assign owner_resp_ready = (key_sel == OWNER_B) ? b_resp_ready : a_resp_ready;
  assign a_resp_block     = (key_sel == OWNER_A) ? result : '0;
  assign b_resp_block     = (key_sel == OWNER_B) ? result : '0;
  assign a_resp_err       = a_resp_valid & err;
  assign b_resp_err       = b_resp_valid & err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_grant   <= OWNER_B;
      cnt          <= '0;
      result       <= '0;
      err          <= 1'b0;
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      core_next    <= 1'b0;
      core_block   <= '0;
      core_keylen  <= KEYLEN_AES128;
      key_sel      <= OWNER_A;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            core_block  <= (grant == OWNER_B) ? b_req_block : a_req_block;
            core_keylen <= (grant == OWNER_B) ? b_req_keylen : a_req_keylen;
            key_sel     <= grant;
            last_grant  <= grant;
            core_next   <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          core_next <= 1'b0;
          cnt       <= '0;
          state     <= ST_BUSY;
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          // A ready pulse in the final watchdog cycle still counts as success.
          if (core_ready) begin
            result       <= core_new_block;
            err          <= 1'b0;
            a_resp_valid <= (key_sel == OWNER_A);
            b_resp_valid <= (key_sel == OWNER_B);
            state        <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            result       <= '0;
            err          <= 1'b1;
            a_resp_valid <= (key_sel == OWNER_A);
            b_resp_valid <= (key_sel == OWNER_B);
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_resp_ready) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - directed self-checking bench for aes_core_arbiter
// Bench core answers known vectors per key_sel and takes 12/16 cycles after sampling next.
module tb_aes_core_arbiter;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MASK_A = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] MASK_B = 128'h3c3c3c3c_c3c3c3c3_12345678_9abcdef0;
  localparam logic [127:0] PA     = 128'h0123456789abcdef_0011223344556677;
  localparam logic [127:0] PB     = 128'hfedcba9876543210_8899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         a_req_valid, a_req_ready, a_req_keylen, a_resp_valid, a_resp_ready, a_resp_err;
  logic [127:0] a_req_block, a_resp_block;
  logic         b_req_valid, b_req_ready, b_req_keylen, b_resp_valid, b_resp_ready, b_resp_err;
  logic [127:0] b_req_block, b_resp_block;
  logic         core_next, core_keylen, core_ready, key_sel;
  logic [127:0] core_block, core_new_block;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  aes_core_arbiter #(.TIMEOUT_CYCLES(20), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_block(a_req_block),
    .a_req_keylen(a_req_keylen), .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .a_resp_block(a_resp_block), .a_resp_err(a_resp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_block(b_req_block),
    .b_req_keylen(b_req_keylen), .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .b_resp_block(b_resp_block), .b_resp_err(b_resp_err),
    .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
    .core_new_block(core_new_block), .core_ready(core_ready), .key_sel(key_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench core and key store
  logic [4:0]   m_cnt;
  logic         m_rdy;
  logic [127:0] m_res;
  logic         m_dead;
  logic         force_rdy;

  function automatic logic [127:0] core_model(input logic [127:0] blk, input logic kl, input logic ks);
    if (blk == PT && kl == 1'b0 && ks == 1'b0) return C128;
    if (blk == PT && kl == 1'b1 && ks == 1'b1) return C256;
    return blk ^ (ks ? MASK_B : MASK_A) ^ {127'b0, kl};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 5'd0;
      m_rdy <= 1'b0;
      m_res <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (core_next) begin
        m_cnt <= core_keylen ? 5'd16 : 5'd12;
        m_res <= core_model(core_block, core_keylen, key_sel);
      end else if (m_cnt != 5'd0) begin
        m_cnt <= m_cnt - 5'd1;
        if (m_cnt == 5'd1 && !m_dead) m_rdy <= 1'b1;
      end
    end
  end

  assign core_ready     = m_rdy | force_rdy;
  assign core_new_block = m_res;

  // Handshake monitor
  int dual_rdy = 0;
  int next_cnt = 0;
  int b_valid_cyc = 0;
  bit grant_q[$];
  logic [127:0] a_hs_q[$];
  logic [127:0] b_hs_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_req_ready && b_req_ready) dual_rdy++;
      if (core_next) next_cnt++;
      if (b_resp_valid) b_valid_cyc++;
      if (a_req_ready && a_req_valid) grant_q.push_back(1'b0);
      if (b_req_ready && b_req_valid) grant_q.push_back(1'b1);
      if (a_resp_valid && a_resp_ready) a_hs_q.push_back(a_resp_block);
      if (b_resp_valid && b_resp_ready) b_hs_q.push_back(b_resp_block);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_req(input bit who, input logic [127:0] blk, input logic kl,
                          output int acc, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    if (who) begin b_req_valid = 1'b1; b_req_block = blk; b_req_keylen = kl; end
    else     begin a_req_valid = 1'b1; a_req_block = blk; a_req_keylen = kl; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (who ? b_req_ready : a_req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    acc = cyc;
    if (who) b_req_valid = 1'b0; else a_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit who, output int rc, output logic [127:0] blk,
                           output logic er, output bit ok);
    ok = 1'b0; rc = 0; blk = '0; er = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (who ? b_resp_valid : a_resp_valid) begin
        ok = 1'b1; rc = cyc;
        blk = who ? b_resp_block : a_resp_block;
        er = who ? b_resp_err : a_resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_resp_err, b_resp_err, core_next} !== 7'b0)
      begin bad++; $display("FAIL reset_flags got=%b exp=0", {a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_resp_err, b_resp_err, core_next}); end
    total++;
    if (core_block !== 128'h0 || a_resp_block !== 128'h0 || b_resp_block !== 128'h0)
      begin bad++; $display("FAIL reset_blocks got=%h/%h/%h exp=0", core_block, a_resp_block, b_resp_block); end
    total++;
    if ({core_keylen, key_sel} !== 2'b00)
      begin bad++; $display("FAIL reset_keylen_keysel got=%b exp=00", {core_keylen, key_sel}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_aes128_a();
    int acc, rc, b0, n0;
    logic [127:0] blk;
    logic er;
    bit ok, ok2;
    b0 = b_valid_cyc; n0 = next_cnt;
    send_req(1'b0, PT, 1'b0, acc, ok);
    wait_resp(1'b0, rc, blk, er, ok2);
    total++;
    if (!ok || !ok2) begin bad++; $display("FAIL a128_handshake got=%0d%0d exp=11", ok, ok2); end
    total++;
    if (blk !== C128) begin bad++; $display("FAIL a128_block got=%h exp=%h", blk, C128); end
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL a128_err got=%b exp=0", er); end
    total++;
    if (rc - acc != 14) begin bad++; $display("FAIL a128_latency got=%0d exp=14", rc - acc); end
    @(negedge clk);
    total++;
    if (next_cnt - n0 != 1) begin bad++; $display("FAIL a128_next_pulses got=%0d exp=1", next_cnt - n0); end
    total++;
    if (b_valid_cyc != b0) begin bad++; $display("FAIL a128_b_idle got=%0d exp=%0d", b_valid_cyc, b0); end
  endtask

  task automatic test_aes256_b();
    int acc, rc, ks_bad;
    logic [127:0] blk;
    logic er;
    bit ok, seen;
    ks_bad = 0; seen = 1'b0; rc = 0; blk = '0; er = 1'b0;
    send_req(1'b1, PT, 1'b1, acc, ok);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_sel !== 1'b1) ks_bad++;
      if (b_resp_valid) begin seen = 1'b1; rc = cyc; blk = b_resp_block; er = b_resp_err; break; end
    end
    total++;
    if (!ok || !seen) begin bad++; $display("FAIL b256_handshake got=%0d%0d exp=11", ok, seen); end
    total++;
    if (blk !== C256 || er !== 1'b0) begin bad++; $display("FAIL b256_block got=%h err=%b exp=%h err=0", blk, er, C256); end
    total++;
    if (rc - acc != 18) begin bad++; $display("FAIL b256_latency got=%0d exp=18", rc - acc); end
    total++;
    if (ks_bad != 0) begin bad++; $display("FAIL b256_key_sel got=%0d bad cycles exp=0", ks_bad); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int g0, a0, b0, d0, na, nb, wa, wb;
    do_reset();
    g0 = grant_q.size(); a0 = a_hs_q.size(); b0 = b_hs_q.size(); d0 = dual_rdy;
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_block = PA; a_req_keylen = 1'b0;
    b_req_valid = 1'b1; b_req_block = PB; b_req_keylen = 1'b0;
    repeat (70) @(negedge clk);
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (grant_q.size() - g0 < 4) begin bad++; $display("FAIL cont_grants got=%0d exp>=4", grant_q.size() - g0); end
    for (int k = 0; k < 4; k++) begin
      if (g0 + k < grant_q.size()) begin
        total++;
        if (grant_q[g0 + k] !== k[0]) begin bad++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", k, grant_q[g0 + k], k[0]); end
      end
    end
    total++;
    if (dual_rdy != d0) begin bad++; $display("FAIL cont_dual_ready got=%0d exp=%0d", dual_rdy, d0); end
    na = 0; nb = 0; wa = 0; wb = 0;
    for (int k = g0; k < grant_q.size(); k++) if (grant_q[k]) nb++; else na++;
    for (int k = a0; k < a_hs_q.size(); k++) if (a_hs_q[k] !== (PA ^ MASK_A)) wa++;
    for (int k = b0; k < b_hs_q.size(); k++) if (b_hs_q[k] !== (PB ^ MASK_B)) wb++;
    total++;
    if (a_hs_q.size() - a0 != na || b_hs_q.size() - b0 != nb)
      begin bad++; $display("FAIL cont_resp_counts got=%0d/%0d exp=%0d/%0d", a_hs_q.size() - a0, b_hs_q.size() - b0, na, nb); end
    total++;
    if (wa != 0 || wb != 0) begin bad++; $display("FAIL cont_resp_data got=%0d/%0d wrong exp=0/0", wa, wb); end
  endtask

  task automatic test_backpressure();
    int rc, stall_bad;
    logic [127:0] blk0, blk;
    logic er;
    bit seen, ok;
    do_reset();
    a_resp_ready = 1'b0;
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_block = PT; a_req_keylen = 1'b0;
    b_req_valid = 1'b1; b_req_block = PB; b_req_keylen = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (a_req_ready) break; end
    @(posedge clk); #1 a_req_valid = 1'b0;
    seen = 1'b0; blk0 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_resp_valid) begin seen = 1'b1; blk0 = a_resp_block; break; end
    end
    total++;
    if (!seen || blk0 !== C128) begin bad++; $display("FAIL bp_first_resp got=%h seen=%0d exp=%h", blk0, seen, C128); end
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_resp_valid !== 1'b1 || a_resp_block !== blk0 || b_req_ready !== 1'b0) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d bad cycles exp=0", stall_bad); end
    @(posedge clk); #1 a_resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (b_req_ready !== 1'b0) begin bad++; $display("FAIL bp_b_ready_early got=%b exp=0", b_req_ready); end
    @(negedge clk);
    total++;
    if (b_req_ready !== 1'b1 || a_resp_valid !== 1'b0)
      begin bad++; $display("FAIL bp_after_hs got=%b%b exp=10", b_req_ready, a_resp_valid); end
    @(posedge clk); #1 b_req_valid = 1'b0;
    wait_resp(1'b1, rc, blk, er, ok);
    total++;
    if (!ok || blk !== (PB ^ MASK_B)) begin bad++; $display("FAIL bp_b_resp got=%h exp=%h", blk, PB ^ MASK_B); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int acc, rc, late_bad;
    logic [127:0] blk;
    logic er;
    bit ok, ok2;
    do_reset();
    m_dead = 1'b1;
    send_req(1'b0, PA, 1'b0, acc, ok);
    wait_resp(1'b0, rc, blk, er, ok2);
    total++;
    if (!ok || !ok2 || er !== 1'b1 || blk !== 128'h0)
      begin bad++; $display("FAIL to_err_resp got=ok%0d%0d err=%b blk=%h exp=err=1 blk=0", ok, ok2, er, blk); end
    total++;
    if (rc - acc != 21) begin bad++; $display("FAIL to_latency got=%0d exp=21", rc - acc); end
    @(negedge clk);
    @(posedge clk); #1 force_rdy = 1'b1;
    @(posedge clk); #1 force_rdy = 1'b0;
    late_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_resp_valid || b_resp_valid) late_bad++;
    end
    total++;
    if (late_bad != 0) begin bad++; $display("FAIL to_late_ready got=%0d resp cycles exp=0", late_bad); end
    m_dead = 1'b0;
    send_req(1'b0, PT, 1'b0, acc, ok);
    wait_resp(1'b0, rc, blk, er, ok2);
    total++;
    if (!ok2 || blk !== C128 || er !== 1'b0 || rc - acc != 14)
      begin bad++; $display("FAIL to_recover got=%h err=%b lat=%0d exp=%h err=0 lat=14", blk, er, rc - acc, C128); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int acc, rc, b0, rst_bad;
    logic [127:0] blk;
    logic er;
    bit ok, ok2;
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      send_req(1'b0, PA ^ 128'(r), 1'b0, acc, ok);
      wait_resp(1'b0, rc, blk, er, ok2);
    end
    b0 = b_valid_cyc;
    send_req(1'b1, PB, 1'b1, acc, ok);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({core_next, core_keylen, key_sel, b_resp_valid, b_req_ready} !== 5'b0 || core_block !== 128'h0)
      begin bad++; $display("FAIL rst_async got=%b blk=%h exp=0", {core_next, core_keylen, key_sel, b_resp_valid, b_req_ready}, core_block); end
    rst_bad = 0;
    repeat (3) begin @(negedge clk); if (b_resp_valid || a_resp_valid) rst_bad++; end
    @(posedge clk); #1 rst_n = 1'b1;
    send_req(1'b0, PT, 1'b0, acc, ok);
    wait_resp(1'b0, rc, blk, er, ok2);
    @(negedge clk);
    total++;
    if (rst_bad != 0 || b_valid_cyc != b0)
      begin bad++; $display("FAIL rst_no_resp got=%0d/%0d exp=0/0", rst_bad, b_valid_cyc - b0); end
    total++;
    if (!ok2 || blk !== C128 || er !== 1'b0 || rc - acc != 14)
      begin bad++; $display("FAIL rst_next_job got=%h err=%b lat=%0d exp=%h err=0 lat=14", blk, er, rc - acc, C128); end
  endtask

  initial begin
    m_dead = 1'b0; force_rdy = 1'b0;
    a_req_valid = 1'b0; a_req_block = '0; a_req_keylen = 1'b0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_block = '0; b_req_keylen = 1'b0; b_resp_ready = 1'b1;
    test_reset();
    test_aes128_a();
    test_aes256_b();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one `AES_encipher` core between two requesters, A and B, each using a valid/ready request and response handshake.
- Arbitrates round-robin between the requesters and latches the winning block and keylen.
- Pulses the core's `next`, holds the core inputs stable until the core's one-cycle `ready` pulse, then returns the result to the owner.
- Drives `key_sel` so the external round-key store serves the owner's key schedule. A watchdog recovers from a core that never signals ready.

Parameters:
- TIMEOUT_CYCLES, 20, cycles in BUSY without `core_ready` before the error response; legal range 17..31.
- CNT_W, 5, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `a_req_valid`  in  1  requester A has a block to encipher
- `a_req_ready`  out  1  A request accepted this cycle
- `a_req_block`  in  128  A plaintext
- `a_req_keylen`  in  1  A key length, 0=AES-128, 1=AES-256
- `a_resp_valid`  out  1  A result available
- `a_resp_ready`  in  1  A consumes result
- `a_resp_block`  out  128  A ciphertext
- `a_resp_err`  out  1  A result is a timeout error
- `b_req_valid`, `b_req_ready`, `b_req_block`, `b_req_keylen`, `b_resp_valid`, `b_resp_ready`, `b_resp_block`, `b_resp_err`: same as the A ports, for requester B
- `core_next`  out  1  one-cycle start pulse to the core
- `core_keylen`  out  1  keylen to the core
- `core_block`  out  128  plaintext to the core
- `core_new_block`  in  128  core result
- `core_ready`  in  1  core one-cycle done pulse
- `key_sel`  out  1  owner index for the key store, 0=A, 1=B

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - state=IDLE; `last_grant`=1, so A wins the first tie.
  - All `*_valid`, `*_req_ready`, `*_err`, `core_next` = 0.
  - `core_block`, result and `*_resp_block` = 0; `core_keylen`=0; `key_sel`=0; counter=0.
- States: IDLE, ISSUE, BUSY, RESP. Encoding constants are shared (see Decomposition).
- IDLE:
  - grant = the valid requester; if both are valid, the one not equal to `last_grant`.
  - `x_req_ready` = (state==IDLE) & (grant==x). This is combinational; at most one is high.
  - On handshake: latch block→`core_block`, keylen→`core_keylen`, owner→`key_sel` and `last_grant`; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - `core_next`=1 for exactly this cycle; clear counter; go to BUSY.
- BUSY:
  - Counter increments every cycle.
  - On `core_ready`=1: capture `core_new_block`, err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: result=0, err=1, go to RESP.
  - If `core_ready` and timeout coincide, `core_ready` wins.
- RESP:
  - `owner_resp_valid`=1 with the registered block and err; the other requester's `resp_valid` stays 0.
  - Hold until `owner_resp_ready`=1, then go to IDLE.
  - `resp_valid` and data are stable while stalled.
  - A new request can be accepted in the cycle after the response handshake.
- `core_block`, `core_keylen` and `key_sel` are constant from ISSUE through the end of BUSY; the core reads them in its INIT and MAIN states.
- `core_ready` outside BUSY is ignored. A core still running after a timeout makes the next job time out too; this is documented behaviour, not a bug.
- Latency with a conforming core:
  - `core_ready` 12 cycles after `core_next` for AES-128, 16 for AES-256.
  - `resp_valid` 14 cycles (AES-128) or 18 cycles (AES-256) after the accept edge.
- No pipelining: one job in flight. Input requests are not buffered beyond the valid/ready hold.
- Deasserting `req_valid` without a handshake is legal; that requester simply loses eligibility.
- Reset mid-operation returns to the reset values immediately. The job is lost and no response is issued.

Decomposition:
- Shared constants in `constant.v`: state encodings (IDLE/ISSUE/BUSY/RESP) and keylen codes (AES-128=0, AES-256=1), matching the encipher core.
- One natural sub-module: `aes_rr_arbiter2`.
  - Combinational 2-way round-robin grant from two valid bits and `last_grant`.
  - The `last_grant` register lives in the parent and updates only on the request handshake.

Test Plan:
- Single AES-128 job:
  - Stimulus: A sends `00112233445566778899aabbccddeeff`; bench key store (`key_sel`=0) holds expanded key `000102…0f`.
  - Required: `core_next` once; `a_resp_block`=`69c4e0d86a7b0430d8cdb78070b4c55a`, err=0, exactly 14 cycles after accept; B outputs stay idle.
- AES-256 on B:
  - Stimulus: B sends `00112233445566778899aabbccddeeff` with key `000102…1f`.
  - Required: `b_resp_block`=`8ea2b7ca516745bfeafc49904b496089`, 18 cycles after accept; `key_sel`=1 throughout BUSY.
- Contention:
  - Stimulus: A and B both valid from reset, continuously.
  - Required: grant order A,B,A,B; never two `req_ready` in one cycle; each response goes only to its owner.
- Back-pressure:
  - Stimulus: hold `a_resp_ready`=0 for 10 cycles in RESP while B is valid.
  - Required: `a_resp_valid` and data stable; `b_req_ready` stays 0 until 1 cycle after the A response handshake.
- Timeout:
  - Stimulus: bench core never pulses `core_ready`; TIMEOUT_CYCLES=20.
  - Required: `a_resp_valid` with err=1, block=0, 20 cycles after ISSUE; a late `core_ready` in IDLE is ignored.
- Reset mid-BUSY:
  - Stimulus: drop `rst_n` in round 5.
  - Required: all outputs return to reset values asynchronously; no `resp_valid`; the next job after release completes correctly.
